// File: rtl/sequence_check.sv
// Checks a player's sequence of switch values against a desired sequence, one button press per value.
// A round ends with a single-cycle pass, mismatch or timeout pulse. Every output comes straight from a register.
module sequence_check #(
  parameter int WIDTH   = 6,
  parameter int DEPTH   = 8,
  parameter int TIMEOUT = 1000,
  localparam int IW     = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [IW-1:0]    seq_len,
  input  logic [WIDTH-1:0] number_input,
  input  logic             button,
  input  logic [WIDTH-1:0] number_desired,
  output logic [IW-1:0]    desired_addr,
  output logic             busy,
  output logic [IW-1:0]    step,
  output logic             input_done,
  output logic             input_correct,
  output logic             input_wrong,
  output logic             timed_out
);

  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } state_t;

  state_t          state_reg, state_next;
  logic [IW-1:0]   len_reg, len_next;
  logic [IW-1:0]   step_reg, step_next;
  logic [TW-1:0]   timer_reg, timer_next;
  logic            button_q;
  logic            zero_pend_reg, zero_pend_next;
  logic            done_reg, done_next;
  logic            correct_reg, correct_next;
  logic            wrong_reg, wrong_next;
  logic            timeout_reg, timeout_next;

  logic            press;
  logic            match;
  logic            last_step;
  logic            expired;
  logic [IW-1:0]   len_clip;

  // A press is the rising edge of the already-synchronised button level.
  assign press     = button & ~button_q;
  assign match     = (number_input == number_desired);
  assign last_step = ((step_reg + IW'(1)) == len_reg);
  assign expired   = (timer_reg == TW'(TIMEOUT - 1));
  assign len_clip  = (seq_len > IW'(DEPTH)) ? IW'(DEPTH) : seq_len;

  always_comb begin
    state_next     = state_reg;
    len_next       = len_reg;
    step_next      = step_reg;
    timer_next     = timer_reg;
    zero_pend_next = 1'b0;
    done_next      = 1'b0;
    correct_next   = 1'b0;
    wrong_next     = 1'b0;
    timeout_next   = 1'b0;

    // An empty round never goes active; it reports a pass on the following edge.
    if (zero_pend_reg) begin
      done_next    = 1'b1;
      correct_next = 1'b1;
    end

    if (start) begin
      len_next   = len_clip;
      step_next  = '0;
      timer_next = '0;
      if (len_clip == '0) begin
        state_next     = IDLE;
        zero_pend_next = 1'b1;
      end else begin
        state_next = ACTIVE;
      end
    end else if (state_reg == ACTIVE) begin
      if (press) begin
        timer_next = '0;
        if (match && last_step) begin
          done_next    = 1'b1;
          correct_next = 1'b1;
          step_next    = '0;
          state_next   = IDLE;
        end else if (match) begin
          step_next = step_reg + IW'(1);
        end else begin
          done_next  = 1'b1;
          wrong_next = 1'b1;
          step_next  = '0;
          state_next = IDLE;
        end
      end else if (expired) begin
        done_next    = 1'b1;
        wrong_next   = 1'b1;
        timeout_next = 1'b1;
        step_next    = '0;
        timer_next   = '0;
        state_next   = IDLE;
      end else begin
        timer_next = timer_reg + TW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      len_reg       <= '0;
      step_reg      <= '0;
      timer_reg     <= '0;
      button_q      <= 1'b0;
      zero_pend_reg <= 1'b0;
      done_reg      <= 1'b0;
      correct_reg   <= 1'b0;
      wrong_reg     <= 1'b0;
      timeout_reg   <= 1'b0;
    end else begin
      state_reg     <= state_next;
      len_reg       <= len_next;
      step_reg      <= step_next;
      timer_reg     <= timer_next;
      button_q      <= button;
      zero_pend_reg <= zero_pend_next;
      done_reg      <= done_next;
      correct_reg   <= correct_next;
      wrong_reg     <= wrong_next;
      timeout_reg   <= timeout_next;
    end
  end

  assign desired_addr  = step_reg;
  assign step          = step_reg;
  assign busy          = (state_reg == ACTIVE);
  assign input_done    = done_reg;
  assign input_correct = correct_reg;
  assign input_wrong   = wrong_reg;
  assign timed_out     = timeout_reg;

endmodule

// File: doc/sequence_check.md
SEQUENCE_CHECK -- requirements
Module: sequence_check

Interface
REQ-001 Parameter WIDTH, default 6: bit width of one entered value and one desired value.
REQ-002 Parameter DEPTH, default 8: maximum number of values in one sequence (2..64).
REQ-003 Parameter TIMEOUT, default 1000: cycles allowed between start/accepted press and the next press (>=2).
REQ-004 Local IW = $clog2(DEPTH+1): width of all index/length signals.
REQ-005 clk  input  1  sole clock; all state changes on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 start  input  1  level sampled each edge; 1 begins a new check round.
REQ-008 seq_len  input  IW  number of values in the round; sampled only on start.
REQ-009 number_input  input  WIDTH  value currently set on the player switches.
REQ-010 button  input  1  physical submit button level, already synchronised to clk.
REQ-011 number_desired  input  WIDTH  desired value at desired_addr, combinational read, valid same cycle.
REQ-012 desired_addr  output  IW  index of the value being compared (equals step).
REQ-013 busy  output  1  high while a round is in progress.
REQ-014 step  output  IW  count of values already accepted in this round.
REQ-015 input_done  output  1  one-cycle pulse when a round ends (pass, mismatch or timeout).
REQ-016 input_correct  output  1  one-cycle pulse, coincident with input_done, on pass only.
REQ-017 input_wrong  output  1  one-cycle pulse, coincident with input_done, on mismatch or timeout.
REQ-018 timed_out  output  1  one-cycle pulse, coincident with input_wrong, on timeout only.

Function
REQ-019 States: IDLE, ACTIVE; all outputs registered.
REQ-020 Press = button==1 at this edge and registered button_q==0; holding button yields exactly one press.
REQ-021 IDLE + start: latch len = min(seq_len, DEPTH), step<=0, timer<=0, go ACTIVE, busy<=1.
REQ-022 Start with seq_len==0: no ACTIVE; next edge pulses input_done and input_correct, stays IDLE.
REQ-023 ACTIVE + press with number_input==number_desired: step<=step+1, timer<=0.
REQ-024 If that accepted press makes step+1==len: same edge pulse input_done and input_correct, busy<=0, step<=0, go IDLE.
REQ-025 ACTIVE + press with mismatch: same edge pulse input_done and input_wrong, busy<=0, step<=0, go IDLE.
REQ-026 ACTIVE, no press: timer increments; when timer==TIMEOUT-1 pulse input_done, input_wrong, timed_out, go IDLE.
REQ-027 Timer saturates only through REQ-026; it never wraps.
REQ-028 Start while ACTIVE: abort round silently (no done pulse), restart per REQ-021.
REQ-029 Start and press on the same edge: start wins; the press is discarded.
REQ-030 Press in IDLE: ignored, no output pulse.
REQ-031 Press on the same edge as timeout expiry: press is evaluated, timeout is not reported.
REQ-032 Pulse outputs are 0 on every edge not named above.
REQ-033 step, desired_addr never exceed len-1 while ACTIVE.

Reset
REQ-034 reset=1 forces IDLE, busy=0, step=0, desired_addr=0, timer=0, button_q=0, all pulse outputs 0, immediately, regardless of clk.
REQ-035 Reset mid-round discards the round; no done pulse on release.
REQ-036 First edge after reset release with button already high counts as a press (button_q=0).

Verification
REQ-037 WIDTH=6, DEPTH=8: start, seq_len=3, desired {5,12,63}, press 5,12,63 -> step 1,2, then input_done+input_correct single pulse, busy=0.
REQ-038 seq_len=3, desired {5,12,63}, press 5 then 7 -> input_done+input_wrong on second press, step returns 0, no input_correct.
REQ-039 TIMEOUT=10, start, no press -> input_done+input_wrong+timed_out exactly 10 edges after start, busy falls same edge.
REQ-040 Hold button high 20 cycles with matching value -> step advances by exactly 1; seq_len=12 with DEPTH=8 -> round passes after 8 presses.
REQ-041 Assert reset asynchronously mid-round after 2 accepted presses -> all outputs 0 before next clk edge, no pulse after release; start with seq_len=0 -> done+correct next edge.
REQ-042 Start asserted on same edge as a matching press while ACTIVE -> step=0, timer=0, no pulses.
